// File: rtl/hc595_scan_ctrl_pkg.sv
// Shared definitions for the 74HC595 display scan controller: frame geometry,
// the common-anode segment table and the scan FSM encoding.
`timescale 1ns/1ps
package hc595_pkg;

    localparam int FRAME_W   = 14;
    localparam int DIGIT_NUM = 6;

    // Common-anode, active-low: bit7 = dp, bits6..0 = g..a
    localparam logic [7:0] SEG_CODE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_LATCH = 2'd3
    } scan_state_e;

    // Shift frame is {seg, one-hot select}; sel[0] leaves the shifter last.
    function automatic logic [FRAME_W-1:0] make_frame(input logic [7:0] seg,
                                                      input logic [2:0] digit);
        logic [DIGIT_NUM-1:0] sel;
        sel = {{(DIGIT_NUM-1){1'b0}}, 1'b1} << digit;
        return {seg, sel};
    endfunction

endpackage

// File: rtl/hc595_scan_ctrl_if.sv
// Display-side bundle: packed digits and display controls in, 595 pin drive out.
`timescale 1ns/1ps
interface hc595_scan_ctrl_if;
    import hc595_pkg::*;

    logic [4*DIGIT_NUM-1:0] disp_data;
    logic [DIGIT_NUM-1:0]   point;
    logic                   lz_en;
    logic                   en;
    logic                   ds;
    logic                   shcp;
    logic                   stcp;
    logic                   oe_n;
    logic                   busy;

    modport master (
        output disp_data, point, lz_en, en,
        input  ds, shcp, stcp, oe_n, busy
    );

    modport slave (
        input  disp_data, point, lz_en, en,
        output ds, shcp, stcp, oe_n, busy
    );

endinterface

// File: rtl/hc595_scan_ctrl_seg7_decode.sv
// Combinational hex-to-segment decoder for a common-anode digit with
// decimal point and blanking.
`timescale 1ns/1ps
module seg7_decode
    import hc595_pkg::*;
(
    input  logic [3:0] value,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    // Blank wins over the decimal point so a suppressed digit is fully dark.
    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            seg = {SEG_CODE[value][7] & ~dp, SEG_CODE[value][6:0]};
        end
    end

endmodule

// File: rtl/hc595_scan_ctrl.sv
// Time-multiplexes six packed digits onto two cascaded 74HC595s: one 14-bit
// {seg, sel} frame is shifted out and latched per scan slot.
`timescale 1ns/1ps
module hc595_scan_ctrl
    import hc595_pkg::*;
#(
    parameter int CLK_DIV      = 2,
    parameter int SCAN_CNT_MAX = 49_999
) (
    input  logic               clk,
    input  logic               reset_n,
    hc595_scan_ctrl_if.slave   bus
);

    localparam int                SCAN_W     = $clog2(SCAN_CNT_MAX + 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST  = SCAN_W'(SCAN_CNT_MAX);
    localparam int                DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]        BIT_LAST   = 4'(FRAME_W - 1);
    localparam logic [2:0]        DIGIT_LAST = 3'(DIGIT_NUM - 1);

    scan_state_e                  state_r;
    logic [SCAN_W-1:0]            scan_cnt_r;
    logic                         scan_tick_s;
    logic [2:0]                   digit_r;
    logic [DIV_W-1:0]             div_cnt_r;
    logic [3:0]                   bit_cnt_r;
    logic [FRAME_W-1:0]           shift_r;
    logic                         ds_r;
    logic                         shcp_r;
    logic                         stcp_r;
    logic                         oe_n_r;
    logic                         busy_r;
    logic                         latched_once_r;
    logic [4*DIGIT_NUM-1:0]       snap_data_r;
    logic [DIGIT_NUM-1:0]         snap_point_r;
    logic                         snap_lz_r;

    logic [4*DIGIT_NUM-1:0]       eff_data_s;
    logic [DIGIT_NUM-1:0]         eff_point_s;
    logic                         eff_lz_s;
    logic [3:0]                   digit_val_s;
    logic                         dp_s;
    logic                         higher_zero_s;
    logic                         blank_s;
    logic [7:0]                   seg_s;
    logic [FRAME_W-1:0]           frame_s;

    // Free-running slot counter; the tick marks the last cycle of each slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt_r <= '0;
        end else if (scan_cnt_r == SCAN_LAST) begin
            scan_cnt_r <= '0;
        end else begin
            scan_cnt_r <= scan_cnt_r + 1'b1;
        end
    end

    assign scan_tick_s = (scan_cnt_r == SCAN_LAST);

    // Digit 0 reads live inputs (and snapshots them); the rest use that snapshot.
    always_comb begin
        eff_data_s  = snap_data_r;
        eff_point_s = snap_point_r;
        eff_lz_s    = snap_lz_r;
        if (digit_r == 3'd0) begin
            eff_data_s  = bus.disp_data;
            eff_point_s = bus.point;
            eff_lz_s    = bus.lz_en;
        end else begin
            eff_data_s  = snap_data_r;
            eff_point_s = snap_point_r;
            eff_lz_s    = snap_lz_r;
        end
    end

    // A digit is blank when it and every more significant digit are zero.
    always_comb begin
        higher_zero_s = 1'b1;
        for (int i = 0; i < DIGIT_NUM; i++) begin
            if ((3'(i) >= digit_r) && (eff_data_s[i*4 +: 4] != 4'h0)) begin
                higher_zero_s = 1'b0;
            end else begin
                higher_zero_s = higher_zero_s;
            end
        end
        blank_s = eff_lz_s && (digit_r != 3'd0) && higher_zero_s;
    end

    assign digit_val_s = eff_data_s[{digit_r, 2'b00} +: 4];
    assign dp_s        = eff_point_s[digit_r];

    seg7_decode u_seg7_decode (
        .value (digit_val_s),
        .dp    (dp_s),
        .blank (blank_s),
        .seg   (seg_s)
    );

    assign frame_s = make_frame(seg_s, digit_r);

    // Scan FSM: load a frame, shift it MSB first on SHCP, then pulse STCP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_IDLE;
            digit_r        <= 3'd0;
            div_cnt_r      <= '0;
            bit_cnt_r      <= 4'd0;
            shift_r        <= '0;
            ds_r           <= 1'b0;
            shcp_r         <= 1'b0;
            stcp_r         <= 1'b0;
            busy_r         <= 1'b0;
            latched_once_r <= 1'b0;
            snap_data_r    <= '0;
            snap_point_r   <= '0;
            snap_lz_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (scan_tick_s && bus.en) begin
                        state_r <= ST_LOAD;
                        busy_r  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (digit_r == 3'd0) begin
                        snap_data_r  <= bus.disp_data;
                        snap_point_r <= bus.point;
                        snap_lz_r    <= bus.lz_en;
                    end
                    shift_r   <= {frame_s[FRAME_W-2:0], 1'b0};
                    ds_r      <= frame_s[FRAME_W-1];
                    shcp_r    <= 1'b0;
                    div_cnt_r <= '0;
                    bit_cnt_r <= 4'd0;
                    state_r   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (div_cnt_r == DIV_LAST) begin
                        div_cnt_r <= '0;
                        if (!shcp_r) begin
                            shcp_r <= 1'b1;
                        end else if (bit_cnt_r == BIT_LAST) begin
                            shcp_r  <= 1'b0;
                            ds_r    <= 1'b0;
                            stcp_r  <= 1'b1;
                            state_r <= ST_LATCH;
                        end else begin
                            shcp_r    <= 1'b0;
                            ds_r      <= shift_r[FRAME_W-1];
                            shift_r   <= {shift_r[FRAME_W-2:0], 1'b0};
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + 1'b1;
                    end
                end
                ST_LATCH: begin
                    if (div_cnt_r == DIV_LAST) begin
                        div_cnt_r      <= '0;
                        stcp_r         <= 1'b0;
                        busy_r         <= 1'b0;
                        latched_once_r <= 1'b1;
                        digit_r        <= (digit_r == DIGIT_LAST) ? 3'd0 : digit_r + 3'd1;
                        state_r        <= ST_IDLE;
                    end else begin
                        div_cnt_r <= div_cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Keep the outputs dark until a valid frame has been latched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oe_n_r <= 1'b1;
        end else if (latched_once_r) begin
            oe_n_r <= ~bus.en;
        end else begin
            oe_n_r <= 1'b1;
        end
    end

    assign bus.ds   = ds_r;
    assign bus.shcp = shcp_r;
    assign bus.stcp = stcp_r;
    assign bus.oe_n = oe_n_r;
    assign bus.busy = busy_r;

endmodule

// File: tb/tb_hc595_scan_ctrl.sv
// Directed scoreboard bench for hc595_scan_ctrl with CLK_DIV=2, SCAN_CNT_MAX=99.
`timescale 1ns/1ps
module tb_hc595_scan_ctrl;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    hc595_scan_ctrl_if bus ();

    hc595_scan_ctrl #(
        .CLK_DIV      (2),
        .SCAN_CNT_MAX (99)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [13:0] exp_q [$];
    logic [13:0] rx_q  [$];
    logic [13:0] sh         = 14'd0;
    int          stcp_run   = 0;
    int          stcp_w     = 0;
    int          stcp_rises = 0;
    int          busy_rises = 0;

    // Bits as a 595 would see them, captured on SHCP rising.
    always @(posedge bus.shcp) sh <= {sh[12:0], bus.ds};

    // Latched frame goes to the receive queue on STCP rising.
    always @(posedge bus.stcp) begin
        rx_q.push_back(sh);
        stcp_rises <= stcp_rises + 1;
    end

    always @(posedge bus.busy) busy_rises <= busy_rises + 1;

    // STCP high width in clocks, sampled on the falling clock edge.
    always @(negedge clk) begin
        if (bus.stcp) begin
            stcp_run <= stcp_run + 1;
        end else begin
            if (stcp_run != 0) stcp_w <= stcp_run;
            stcp_run <= 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [13:0] mk(input logic [7:0] seg, input int dig);
        logic [5:0] sel;
        sel = 6'b000001 << dig;
        return {seg, sel};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [13:0] e);
        exp_q.push_back(e);
    endtask

    task automatic check_frame(input string tag);
        int          n;
        logic [13:0] got;
        logic [13:0] want;
        n = 0;
        while (rx_q.size() == 0 && n < 400) begin
            tick(1);
            n++;
        end
        check({tag, "_arrive"}, 32'(rx_q.size() != 0), 32'd1);
        if (rx_q.size() != 0 && exp_q.size() != 0) begin
            got  = rx_q.pop_front();
            want = exp_q.pop_front();
            check(tag, 32'(got), 32'(want));
        end
    endtask

    task automatic expect_frame(input logic [13:0] e, input string tag);
        push_exp(e);
        check_frame(tag);
    endtask

    task automatic wait_frame_start(input string tag);
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < 400) begin
            tick(1);
            n++;
        end
        while (bus.busy !== 1'b1 && n < 800) begin
            tick(1);
            n++;
        end
        check({tag, "_start"}, 32'(bus.busy === 1'b1), 32'd1);
    endtask

    logic [7:0] segs_b [6] = '{8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'h82};

    initial begin
        int n;
        int m;
        int r0;
        int b0;

        reset_n       = 1'b0;
        bus.disp_data = 24'h123456;
        bus.point     = 6'b000000;
        bus.lz_en     = 1'b0;
        bus.en        = 1'b1;
        tick(3);
        check("reset_outs", 32'({bus.ds, bus.shcp, bus.stcp, bus.oe_n, bus.busy}), 32'b00010);

        // First frame: load timing, busy length, bit stream, latch pulse
        reset_n = 1'b1;
        push_exp(mk(8'h82, 0));
        n = 0;
        while (bus.busy !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        check("first_load_cycle", 32'(n), 32'd100);
        m = 0;
        while (bus.busy === 1'b1 && m < 200) begin
            tick(1);
            m++;
        end
        check("busy_len", 32'(m), 32'd59);
        check_frame("frame_d0");
        tick(2);
        check("stcp_width", 32'(stcp_w), 32'd2);
        check("stcp_pulses", 32'(stcp_rises), 32'd1);
        check("oe_on", 32'(bus.oe_n), 32'd0);

        // Full scan of 123456, then wrap to digit 0
        for (int i = 0; i < 6; i++) begin
            expect_frame(mk(segs_b[i], (i + 1) % 6), $sformatf("scan%0d", i));
        end

        // Snapshot: change mid-scan only appears from the next digit-0 frame
        bus.disp_data = 24'h111111;
        for (int d = 1; d < 6; d++) begin
            expect_frame(mk(segs_b[d-1], d), $sformatf("old_snap_d%0d", d));
        end
        expect_frame(mk(8'hF9, 0), "ones_d0");
        expect_frame(mk(8'hF9, 1), "ones_d1");
        push_exp(mk(8'hF9, 2));
        wait_frame_start("tear_d2");
        tick(5);
        bus.disp_data = 24'h222222;
        check_frame("tear_d2");
        for (int d = 3; d < 6; d++) begin
            expect_frame(mk(8'hF9, d), $sformatf("no_tear_d%0d", d));
        end
        expect_frame(mk(8'hA4, 0), "new_d0");

        // Leading-zero suppression with decimal point on digit 1
        bus.disp_data = 24'h000070;
        bus.point     = 6'b000010;
        bus.lz_en     = 1'b1;
        for (int d = 1; d < 6; d++) begin
            expect_frame(mk(8'hA4, d), $sformatf("twos_d%0d", d));
        end
        expect_frame(mk(8'hC0, 0), "lz_d0");
        expect_frame(mk(8'h78, 1), "lz_d1_dp");
        for (int d = 2; d < 6; d++) begin
            expect_frame(mk(8'hFF, d), $sformatf("lz_blank_d%0d", d));
        end

        // Drop en mid-shift: frame completes, nothing further loads
        push_exp(mk(8'hC0, 0));
        wait_frame_start("en_drop");
        tick(10);
        bus.en = 1'b0;
        r0 = stcp_rises;
        tick(1);
        check("oe_off", 32'(bus.oe_n), 32'd1);
        check_frame("en_drop_frame");
        tick(5);
        check("en_drop_pulse", 32'(stcp_rises - r0), 32'd1);
        b0 = busy_rises;
        tick(300);
        check("no_load_while_off", 32'(busy_rises - b0), 32'd0);
        check("no_rx_while_off", 32'(rx_q.size()), 32'd0);
        bus.en = 1'b1;
        tick(1);
        check("oe_back", 32'(bus.oe_n), 32'd0);
        expect_frame(mk(8'h78, 1), "resume_d1");

        // Asynchronous reset during bit 7 of the digit-2 frame
        wait_frame_start("pre_reset");
        tick(30);
        reset_n = 1'b0;
        #1;
        check("reset_mid", 32'({bus.ds, bus.shcp, bus.stcp, bus.oe_n, bus.busy}), 32'b00010);
        tick(2);
        check("reset_no_latch", 32'(rx_q.size()), 32'd0);
        reset_n = 1'b1;
        push_exp(mk(8'hC0, 0));
        wait_frame_start("post_reset");
        check("oe_hold", 32'(bus.oe_n), 32'd1);
        check_frame("post_reset_d0");
        check("oe_hold_latch", 32'(bus.oe_n), 32'd1);
        tick(4);
        check("oe_after_latch", 32'(bus.oe_n), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hc595_scan_ctrl.md
Name: hc595_scan_ctrl

Overview:
Drives the 6-digit 7-segment display through two cascaded 74HC595 shift registers. It takes the packed 24-bit BCD/hex display word produced by the key/parameter control path and time-multiplexes it. For each digit it serially shifts a 14-bit frame {seg[7:0], sel[5:0]} and then latches it, one digit per scan slot, continuously. It sits between key_control's disp_data output and the board-level DS/SHCP/STCP/OE pins.

Parameters:
CLK_DIV, 2, clk cycles per SHCP half-period. Bit period = 2*CLK_DIV clks.
SCAN_CNT_MAX, 49_999, scan slot length minus 1 in clk cycles (1 ms at 50 MHz).
Constraint: SCAN_CNT_MAX+1 > 29*CLK_DIV+2.

Ports:
clk  in  1  system clock, 50 MHz.
reset_n  in  1  asynchronous, active-low reset.
disp_data  in  24  six 4-bit digits; digit i = disp_data[4i+3:4i]; digit 0 is rightmost.
point  in  6  decimal point enable per digit, active-high.
lz_en  in  1  leading-zero suppression enable.
en  in  1  display enable.
ds  out  1  serial data to first 595.
shcp  out  1  shift clock; 595 samples ds on its rising edge.
stcp  out  1  storage latch clock.
oe_n  out  1  595 output enable, active-low.
busy  out  1  high while a frame is in progress.

Behaviour:
- Reset (asynchronous, any time, including mid-frame): ds=0, shcp=0, stcp=0, oe_n=1, busy=0. Scan counter, digit index and FSM return to 0/IDLE; snapshot registers are cleared.
- Scan counter: free-running, 0..SCAN_CNT_MAX, wraps to 0. On the cycle it equals SCAN_CNT_MAX it issues scan_tick.
- FSM states:
  - IDLE -> LOAD on scan_tick && en.
  - LOAD (1 clk): if digit index = 0, snapshot disp_data, point and lz_en. Build the frame for the current digit; set busy=1. -> SHIFT.
  - SHIFT: 14 bits, MSB first (seg[7] first, sel[0] last). For each bit, ds is updated while shcp is low; shcp stays low CLK_DIV clks, then high CLK_DIV clks. After bit 14, shcp=0. -> LATCH.
  - LATCH: stcp=1 for CLK_DIV clks, then 0. Digit index advances 5->0 wrap. busy=0. -> IDLE.
- Frame latency: LOAD to stcp falling = 1 + 28*CLK_DIV + CLK_DIV clks.
- scan_tick arriving while busy is dropped. The digit index advances only on completed frames.
- Frame contents:
  - sel is one-hot active-high: sel[i]=1 for digit i.
  - seg is common-anode, active-low: bit7=dp, bits6..0 = g..a.
  - Decode table: 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E.
  - If point[i] is set, seg[7] is cleared.
- Leading-zero suppression: when the snapshot lz_en=1, digit i (5..1) is blanked (seg=FF, dp included) if digit i and all higher digits are 0. Digit 0 is never blanked.
- Snapshot: digits 1..5 use the snapshot taken at digit 0. A mid-scan disp_data change appears from the next digit-0 frame, so no tearing occurs.
- oe_n:
  - Stays 1 until the first stcp falling edge after reset.
  - Thereafter equals ~en, registered (1 clk delay).
  - en deassert mid-frame: the current frame completes, no new LOAD is issued, and oe_n=1.

Decomposition:
- Shared package hc595_pkg holds:
  - FRAME_W=14 and DIGIT_NUM=6;
  - the 16-entry SEG_CODE constant array and SEG_BLANK=8'hFF;
  - the FSM state encoding.
- Sub-module seg7_decode (combinational): 4-bit value, dp, blank -> seg[7:0].
- Scan counter, FSM, shifter and snapshot logic stay in hc595_scan_ctrl.

Test Plan:
- CLK_DIV=2, SCAN_CNT_MAX=99, disp_data=24'h123456, point=0, lz_en=0, en=1:
  - first LOAD occurs at cycle 100 after reset release;
  - bits sampled on shcp rising edges are 10000010_000001 (6, sel0);
  - stcp is high for 2 clks;
  - busy lasts 59 clks.
- Same setup, run 6 slots: frames carry seg 82,92,99,B0,A4,F9 with sel 000001..100000 in order, then wrap to digit 0.
- disp_data=24'h000070, point=6'b000010, lz_en=1:
  - digits 5..2 show seg FF;
  - digit 1 shows F8 with dp cleared -> 78;
  - digit 0 shows C0.
- Change disp_data from 24'h111111 to 24'h222222 during the digit-2 frame: digits 2..5 still show F9; the next digit-0 frame shows A4.
- Assert reset_n=0 mid-SHIFT (bit 7): ds/shcp/stcp go to 0 and oe_n to 1 immediately. After release, the first frame is digit 0 again, and oe_n stays 1 until that frame latches.
- Drop en during SHIFT: the frame completes and stcp pulses once; no further LOAD occurs; oe_n=1 one clk after en low. Raise en: the next scan_tick resumes at the following digit.
